// File: rtl/rgb_pwm_sched_pkg.sv
// Shared types and constants for the RGB PWM scheduler.
// RGB_PWM_GAMMA_EN selects the squared (gamma ~2) duty mapping; default is linear.
package rgb_pwm_sched_pkg;

    localparam int LEVEL_W = 8;
    localparam int R_HI    = 23;
    localparam int G_HI    = 15;
    localparam int B_HI    = 7;
    localparam int GNT_A   = 0;
    localparam int GNT_B   = 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BND,
        FADE
    } state_e;

    typedef logic [LEVEL_W-1:0] level_t;

    function automatic level_t duty_of(input level_t lvl);
`ifdef RGB_PWM_GAMMA_EN
        logic [2*LEVEL_W-1:0] sq;
        sq = {{LEVEL_W{1'b0}}, lvl} * {{LEVEL_W{1'b0}}, lvl};
        return sq[2*LEVEL_W-1:LEVEL_W];
`else
        return lvl;
`endif
    endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One colour channel: current level, fade stepper, boundary-latched duty and comparator.
module rgb_pwm_chan
    import rgb_pwm_sched_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  level_t tgt,
    input  logic   load_en,
    input  logic   step_en,
    input  logic   bnd,
    input  level_t cnt,
    output level_t cur_nxt,
    output logic   pwm
);

    level_t cur_q, cur_d;
    level_t duty_q, duty_d;

    always_comb begin
        cur_d  = cur_q;
        duty_d = duty_q;
        if (load_en) begin
            cur_d = tgt;
        end else if (step_en) begin
            if (cur_q < tgt) begin
                cur_d = cur_q + level_t'(1);
            end else if (cur_q > tgt) begin
                cur_d = cur_q - level_t'(1);
            end
        end
        // Latch from the next level so a step/fade change lands on this very boundary.
        if (bnd) begin
            duty_d = duty_of(cur_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            duty_q <= '0;
        end else begin
            cur_q  <= cur_d;
            duty_q <= duty_d;
        end
    end

    assign cur_nxt = cur_d;
    assign pwm     = (cnt < duty_q);

endmodule

// File: rtl/rgb_pwm_sched.sv
// RGB LED PWM scheduler: prescaler, shared period counter, A-priority arbiter and fade FSM.
// Build option RGB_PWM_GAMMA_EN (see package) changes only the duty mapping.
module rgb_pwm_sched
    import rgb_pwm_sched_pkg::*;
#(
    parameter int unsigned PRESC    = 12,
    parameter int unsigned FADE_DIV = 4
) (
    input  logic        int_osc,
    input  logic        rstn,
    input  logic        a_valid,
    input  logic        b_valid,
    output logic        a_ready,
    output logic        b_ready,
    input  logic [23:0] a_rgb,
    input  logic [23:0] b_rgb,
    input  logic        a_fade,
    input  logic        b_fade,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        led_en,
    output logic        busy,
    output logic [1:0]  grant
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    level_t          cnt_q, cnt_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [23:0]     tgt_q, tgt_d;
    logic            fade_q, fade_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            led_en_q, led_en_d;

    logic   tick, bnd, step_pt, load_en, all_eq;
    level_t r_nxt, g_nxt, b_nxt;

    assign a_ready = (state_q == IDLE);
    assign b_ready = (state_q == IDLE) & ~a_valid;

    assign tick    = (presc_q == PW'(PRESC - 1));
    assign bnd     = tick && (cnt_q == '1);
    assign step_pt = (state_q == FADE) && bnd && (fcnt_q == FW'(FADE_DIV - 1));
    assign load_en = (state_q == WAIT_BND) && bnd;
    assign all_eq  = (r_nxt == tgt_q[R_HI -: LEVEL_W]) &&
                     (g_nxt == tgt_q[G_HI -: LEVEL_W]) &&
                     (b_nxt == tgt_q[B_HI -: LEVEL_W]);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = tick ? cnt_q + level_t'(1) : cnt_q;
        state_d = state_q;
        fcnt_d  = fcnt_q;
        tgt_d   = tgt_q;
        fade_d  = fade_q;
        grant_d = '0;
        unique case (state_q)
            IDLE: begin
                if (a_valid) begin
                    tgt_d          = a_rgb;
                    fade_d         = a_fade;
                    grant_d[GNT_A] = 1'b1;
                    state_d        = LOAD;
                end else if (b_valid) begin
                    tgt_d          = b_rgb;
                    fade_d         = b_fade;
                    grant_d[GNT_B] = 1'b1;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                fcnt_d  = '0;
                state_d = fade_q ? FADE : WAIT_BND;
            end
            WAIT_BND: begin
                if (bnd) state_d = IDLE;
            end
            FADE: begin
                if (step_pt) begin
                    fcnt_d = '0;
                    if (all_eq) state_d = IDLE;
                end else if (bnd) begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
        endcase
        busy_d   = (state_d != IDLE);
        led_en_d = (r_nxt != '0) || (g_nxt != '0) || (b_nxt != '0) || busy_d;
    end

    always_ff @(posedge int_osc or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            fcnt_q   <= '0;
            tgt_q    <= '0;
            fade_q   <= 1'b0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            led_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            fcnt_q   <= fcnt_d;
            tgt_q    <= tgt_d;
            fade_q   <= fade_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            led_en_q <= led_en_d;
        end
    end

    rgb_pwm_chan u_chan_r (
        .clk(int_osc), .rst_n(rstn), .tgt(tgt_q[R_HI -: LEVEL_W]),
        .load_en(load_en), .step_en(step_pt), .bnd(bnd), .cnt(cnt_q),
        .cur_nxt(r_nxt), .pwm(pwm_r)
    );

    rgb_pwm_chan u_chan_g (
        .clk(int_osc), .rst_n(rstn), .tgt(tgt_q[G_HI -: LEVEL_W]),
        .load_en(load_en), .step_en(step_pt), .bnd(bnd), .cnt(cnt_q),
        .cur_nxt(g_nxt), .pwm(pwm_g)
    );

    rgb_pwm_chan u_chan_b (
        .clk(int_osc), .rst_n(rstn), .tgt(tgt_q[B_HI -: LEVEL_W]),
        .load_en(load_en), .step_en(step_pt), .bnd(bnd), .cnt(cnt_q),
        .cur_nxt(b_nxt), .pwm(pwm_b)
    );

    assign grant  = grant_q;
    assign busy   = busy_q;
    assign led_en = led_en_q;

endmodule

// File: tb/tb_rgb_pwm_sched.sv
// Self-checking bench for rgb_pwm_sched: directed scenarios plus random step/fade requests
// checked against per-period duty expectations derived from level arithmetic.
module tb_rgb_pwm_sched;

    localparam int PRESC_TB = 2;
    localparam int PER      = 256 * PRESC_TB;

    logic        int_osc = 1'b0;
    logic        rstn    = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [23:0] a_rgb = '0, b_rgb = '0;
    logic        a_fade = 1'b0, b_fade = 1'b0;
    logic        pwm_r, pwm_g, pwm_b, led_en, busy;
    logic [1:0]  grant;

    int tests_run    = 0;
    int tests_failed = 0;
    int lvl [3];
    int unsigned ec;

    rgb_pwm_sched #(.PRESC(PRESC_TB), .FADE_DIV(1)) dut (
        .int_osc(int_osc), .rstn(rstn),
        .a_valid(a_valid), .b_valid(b_valid),
        .a_ready(a_ready), .b_ready(b_ready),
        .a_rgb(a_rgb), .b_rgb(b_rgb),
        .a_fade(a_fade), .b_fade(b_fade),
        .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
        .led_en(led_en), .busy(busy), .grant(grant)
    );

    always #5 int_osc = ~int_osc;

    // Clock edges since reset release; a PWM period boundary falls on every PER-th edge.
    always @(posedge int_osc or negedge rstn) begin
        if (!rstn) ec <= 0;
        else       ec <= ec + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gam(input int l);
`ifdef RGB_PWM_GAMMA_EN
        return (l * l) >> 8;
`else
        return l;
`endif
    endfunction

    function automatic int fade_level(input int c, input int t, input int k);
        if (t > c) return (c + k > t) ? t : c + k;
        return (c - k < t) ? t : c - k;
    endfunction

    function automatic int absd(input int x, input int y);
        return (x > y) ? x - y : y - x;
    endfunction

    task automatic sync_bnd();
        int n = 0;
        do begin
            @(negedge int_osc);
            n++;
        end while ((ec % PER) != 0 && n < PER + 8);
        if ((ec % PER) != 0) check("sync_timeout", int'(ec % PER), 0);
    endtask

    // Called on the first negedge of a period; counts high samples over the whole period.
    task automatic measure(input string tag, input int lr, input int lg, input int lb, input int ebusy);
        int hr = 0, hg = 0, hb = 0;
        check({tag, "_busy"}, int'(busy), ebusy);
        check({tag, "_led_en"}, int'(led_en), ((lr | lg | lb) != 0 || ebusy != 0) ? 1 : 0);
        for (int i = 0; i < PER; i++) begin
            if (i != 0) @(negedge int_osc);
            hr += int'(pwm_r);
            hg += int'(pwm_g);
            hb += int'(pwm_b);
        end
        check({tag, "_r_samples"}, hr, gam(lr) * PRESC_TB);
        check({tag, "_g_samples"}, hg, gam(lg) * PRESC_TB);
        check({tag, "_b_samples"}, hb, gam(lb) * PRESC_TB);
    endtask

    task automatic do_req(input bit use_b, input logic [23:0] rgb, input bit fd, input string tag);
        if (use_b) begin
            b_valid = 1'b1; b_rgb = rgb; b_fade = fd;
        end else begin
            a_valid = 1'b1; a_rgb = rgb; a_fade = fd;
        end
        @(negedge int_osc);
        check({tag, "_grant"}, int'(grant), use_b ? 2 : 1);
        check({tag, "_busy_after"}, int'(busy), 1);
        check({tag, "_a_ready_busy"}, int'(a_ready), 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic step_and_check(input bit use_b, input logic [23:0] rgb, input string tag);
        sync_bnd();
        do_req(use_b, rgb, 1'b0, tag);
        sync_bnd();
        lvl[0] = int'(rgb[23:16]);
        lvl[1] = int'(rgb[15:8]);
        lvl[2] = int'(rgb[7:0]);
        measure(tag, lvl[0], lvl[1], lvl[2], 0);
    endtask

    initial begin
        int t [3];
        int nsteps, viol, gotb, n;
        bit use_b, fd;
        logic [23:0] v;

        lvl = '{0, 0, 0};
        repeat (3) @(negedge int_osc);
        check("rst_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
        check("rst_led_en", int'(led_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_grant", int'(grant), 0);
        rstn = 1'b1;
        @(negedge int_osc);
        check("rel_a_ready", int'(a_ready), 1);
        check("rel_b_ready", int'(b_ready), 1);

        for (int p = 0; p < 10; p++) begin
            sync_bnd();
            check("idle_b_ready", int'(b_ready), 1);
            measure("idle", 0, 0, 0, 0);
        end

        step_and_check(1'b0, 24'h8000FF, "stepA");

        // Simultaneous requests: A wins, B waits for IDLE and is taken right after A's boundary.
        sync_bnd();
        a_valid = 1'b1; a_rgb = 24'h112233; a_fade = 1'b0;
        b_valid = 1'b1; b_rgb = 24'hA0B0C0; b_fade = 1'b0;
        @(negedge int_osc);
        check("ab_grant_a", int'(grant), 1);
        check("ab_b_ready", int'(b_ready), 0);
        a_valid = 1'b0;
        viol = 0; gotb = 0; n = 0;
        while (gotb == 0 && n < 3 * PER) begin
            @(negedge int_osc);
            n++;
            if (grant == 2'b10) gotb = 1;
            else if (busy && b_ready) viol++;
        end
        b_valid = 1'b0;
        check("ab_b_granted", gotb, 1);
        check("ab_b_grant_phase", int'(ec % PER), 1);
        check("ab_b_ready_while_busy", viol, 0);
        sync_bnd();
        lvl = '{8'hA0, 8'hB0, 8'hC0};
        measure("ab_b_level", lvl[0], lvl[1], lvl[2], 0);

        step_and_check(1'b0, 24'h000000, "zero");

        sync_bnd();
        do_req(1'b1, 24'h030000, 1'b1, "fadeB");
        for (int k = 1; k <= 3; k++) begin
            sync_bnd();
            measure("fadeB", k, 0, 0, (k < 3) ? 1 : 0);
        end
        lvl = '{3, 0, 0};

        step_and_check(1'b0, 24'h10FF01, "edge_lv");

        for (int it = 0; it < 6; it++) begin
            use_b = 1'($urandom_range(0, 1));
            fd    = 1'($urandom_range(0, 1));
            nsteps = 1;
            for (int c = 0; c < 3; c++) begin
                if (fd) begin
                    t[c] = lvl[c] + int'($urandom_range(0, 8)) - 4;
                    if (t[c] < 0)   t[c] = 0;
                    if (t[c] > 255) t[c] = 255;
                    if (absd(t[c], lvl[c]) > nsteps) nsteps = absd(t[c], lvl[c]);
                end else begin
                    t[c] = int'($urandom_range(0, 255));
                end
            end
            v = {t[0][7:0], t[1][7:0], t[2][7:0]};
            sync_bnd();
            do_req(use_b, v, fd, "rnd");
            for (int k = 1; k <= nsteps; k++) begin
                sync_bnd();
                if (fd)
                    measure("rnd_fade", fade_level(lvl[0], t[0], k), fade_level(lvl[1], t[1], k),
                            fade_level(lvl[2], t[2], k), (k < nsteps) ? 1 : 0);
                else
                    measure("rnd_step", t[0], t[1], t[2], 0);
            end
            lvl = t;
        end

        // Reset in the middle of a fade period once the level has reached 0x40.
        step_and_check(1'b0, 24'h3C3C3C, "pre_rst");
        sync_bnd();
        do_req(1'b0, 24'h505050, 1'b1, "fade_rst");
        for (int k = 1; k <= 3; k++) begin
            sync_bnd();
            measure("fade_rst", 8'h3C + k, 8'h3C + k, 8'h3C + k, 1);
        end
        sync_bnd();
        repeat (200) @(negedge int_osc);
        check("mid_fade_pwm_r", int'(pwm_r), (gam(8'h40) * PRESC_TB > 200) ? 1 : 0);
        #3 rstn = 1'b0;
        #1;
        check("async_rst_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
        check("async_rst_led_en", int'(led_en), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_a_ready", int'(a_ready), 1);
        repeat (3) @(negedge int_osc);
        rstn = 1'b1;
        lvl = '{0, 0, 0};
        sync_bnd();
        measure("post_rst", 0, 0, 0, 0);
        step_and_check(1'b1, 24'h00FF00, "recover");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
